dlx_prog_loader: RTL and testbench
==================================

# dlx_prog_loader

Program loader and instruction-memory responder for the `dlxpipeline` fetch port; it is the writer side of the instruction ROM that the pipeline reads. It accepts a program as a stream of 32-bit words over a valid/ready handshake and stores them in an internal word array. It holds the pipeline in reset until loading completes, then serves `pc` fetches with one-cycle registered latency, with the same timing as `ROM_BLOCK`. Words at indices never loaded read as NOP.

## Interface
- `DEPTH`, 64: instruction words stored; power of two.
- `NOP_WORD`, 32'h0000_0000: word returned for unloaded or out-of-range fetches.
- `RELEASE_CYCLES`, 2: cycles `cpu_reset` stays low after load completes; must be ≥1.

Ports:
- `clock`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-low.
- `ld_valid`  in  1: loader word valid.
- `ld_data`  in  32: instruction word.
- `ld_last`  in  1: qualifies the final word of the program.
- `ld_ready`  out  1: loader may transfer.
- `reload`  in  1: single-cycle request, honoured only in RUN.
- `pc`  in  32: byte address from the pipeline; word index is `pc[2+:log2(DEPTH)]`.
- `inst_out`  out  32: registered fetch data.
- `cpu_reset`  out  1: active-low reset to `dlxpipeline`.
- `load_done`  out  1: high in RUN.
- `word_count`  out  log2(DEPTH)+1: words loaded.
- `err_trunc`  out  1: sticky; DEPTH words accepted without `ld_last`.

## Operation
- States: LOAD, HOLD, RUN.
- Reset (`reset`=0 at edge): state←LOAD, `word_count`←0, hold counter←0, `err_trunc`←0, `inst_out`←NOP_WORD, `cpu_reset`←0, `load_done`←0, `ld_ready`←0. Array contents are not cleared. Reset asserted mid-load or mid-run has the same effect.
- LOAD:
  - `ld_ready`=1 when `word_count`<DEPTH.
  - On a transfer (`ld_valid`&`ld_ready`): `mem[word_count]`←`ld_data`, then `word_count`++.
  - Transfer with `ld_last`=1 → HOLD.
  - Transfer that makes `word_count`==DEPTH with `ld_last`=0 → HOLD and `err_trunc`←1.
  - `ld_valid` high with zero words and no `ld_last` stays in LOAD indefinitely.
- HOLD:
  - `ld_ready`=0 and `cpu_reset`=0.
  - Counter runs from 0 to RELEASE_CYCLES−1, then → RUN.
- RUN:
  - `cpu_reset`=1, `load_done`=1, `ld_ready`=0; `ld_valid` is ignored.
  - `reload`=1 → LOAD: `word_count`←0, `cpu_reset`←0 on the same edge. `err_trunc` is kept.
- Fetch, every cycle in every state:
  - Index i = `pc[2+:log2(DEPTH)]`.
  - `inst_out`←`mem[i]` if state==RUN, i<`word_count`, and `pc`<4·DEPTH. Otherwise `inst_out`←NOP_WORD.
  - `pc[1:0]` is ignored.
- `word_count` saturates at DEPTH; it does not wrap.

## Timing
- Fetch latency is 1 cycle: `pc` sampled at edge k appears on `inst_out` after edge k.
- Load: one word per cycle at full throughput. `ld_ready` is a registered function of state and `word_count`; it does not depend on `ld_valid`.
- The last-word edge enters HOLD. `cpu_reset` rises RELEASE_CYCLES edges later; the pipeline's first fetch occurs in RUN.
- `reload` in the same cycle as `ld_valid`: no transfer, because `ld_ready` was 0.
- Write-to-read of the same index: not possible, since writes occur only outside RUN.

## Structure
- Shared package `dlx_pkg` holds:
  - `NOP_WORD` default
  - loader state enum {LOAD, HOLD, RUN}
  - `DLX_WORD_W`=32
- Sub-module `dlx_imem_array`: synchronous write, registered read, DEPTH×32. It contains no reset logic, so it maps to block RAM.
- The top level contains the FSM, counters, fetch qualification and the NOP mux.

## Test plan
- **Nominal load and fetch:** reset low 3 cycles, then high. Load 3 words (ADDI R1,R2,15 = 32'h4022_000F; 32'h4043_000F; `ld_last` on 32'h0000_0000). → `word_count`=3, `cpu_reset` rises 2 cycles after the last transfer. `pc`=4 gives `inst_out`=32'h4043_000F the next cycle.
- **Unloaded and out-of-range fetch:** after the load above, `pc`=12 and `pc`=256 → NOP_WORD. `pc`=5 → same word as `pc`=4.
- **Truncation:** stream 64 words with `ld_last`=0. → `ld_ready` falls after the 64th transfer, `err_trunc`=1, RUN reached. A 65th `ld_valid` is not accepted.
- **Backpressure and gaps:** `ld_valid` toggled 1,0,1,0,1(last). → exactly 3 transfers, stored in order. `cpu_reset` stays 0 throughout LOAD.
- **Reload:** in RUN, pulse `reload` together with `ld_valid`. → `cpu_reset`=0 next cycle, `word_count`=0, no transfer that cycle. A new 2-word program then replaces the old one, and index 2 reads NOP.
- **Reset mid-operation:** assert `reset` during HOLD and during RUN. → all outputs return to reset values on the next edge, `err_trunc` clears, and a fetch returns NOP until a new load completes.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX program loader and instruction memory.
package dlx_pkg;

  localparam int DLX_WORD_W = 32;

  // Returned for fetches that fall outside the loaded program.
  localparam logic [DLX_WORD_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // LOAD: accepting words, HOLD: pipeline still in reset, RUN: serving fetches.
  typedef enum logic [1:0] {
    LOAD,
    HOLD,
    RUN
  } ld_state_e;

endpackage

// File: rtl/dlx_prog_loader_if.sv
// Valid/ready word stream that carries a program into the loader.
interface dlx_prog_loader_if;
  import dlx_pkg::*;

  logic                  ld_valid;
  logic [DLX_WORD_W-1:0] ld_data;
  logic                  ld_last;
  logic                  ld_ready;

  modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
  modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);
endinterface

// File: rtl/dlx_imem_array.sv
// Instruction word array: synchronous write port, registered read port.
module dlx_imem_array
  import dlx_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DLX_WORD_W-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DLX_WORD_W-1:0] rdata
);

  logic [DLX_WORD_W-1:0] mem [DEPTH];

  // Write the loaded word and register the fetch read every cycle.
  // NOTE: no reset on the array or its read register, so this maps onto block
  // RAM; the top level masks stale or unloaded contents with NOP instead.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dlx_prog_loader.sv
// Program loader and instruction-memory responder for the DLX fetch port.
// Streams a program into the array, holds the pipeline in reset until the load
// settles, then answers pc fetches with one cycle of latency.
module dlx_prog_loader
  import dlx_pkg::*;
#(
  parameter int                    DEPTH          = 64,
  parameter logic [DLX_WORD_W-1:0] NOP_WORD       = NOP_WORD_DEFAULT,
  parameter int                    RELEASE_CYCLES = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  dlx_prog_loader_if.slave      ld,
  input  logic                  reload,
  input  logic [DLX_WORD_W-1:0] pc,
  output logic [DLX_WORD_W-1:0] inst_out,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic [CW-1:0]         word_count,
  output logic                  err_trunc
);

  localparam int HW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  ld_state_e             state, state_next;
  logic [CW-1:0]         count_next;
  logic [HW-1:0]         hold_cnt, hold_next;
  logic                  err_next;
  logic                  ready_q;
  logic                  xfer;
  logic                  wr_en;
  logic                  fetch_ok;
  logic [DLX_WORD_W-1:0] word_addr;
  logic [AW-1:0]         idx;
  logic                  fetch_hit;
  logic [DLX_WORD_W-1:0] rdata;

  assign ld.ld_ready = ready_q;
  assign xfer        = (state == LOAD) && ld.ld_valid && ready_q;

  // Byte address to word address; the low two bits drop out of the shift.
  assign word_addr = pc >> 2;
  assign idx       = word_addr[AW-1:0];
  assign fetch_hit = (state == RUN) && ({1'b0, idx} < word_count) &&
                     (word_addr < DLX_WORD_W'(DEPTH));

  // Next-state, counter and write-enable decode for the loader FSM.
  // NOTE: every signal gets a default before the case, so no latch is inferred.
  always_comb begin
    state_next = state;
    count_next = word_count;
    hold_next  = '0;
    err_next   = err_trunc;
    wr_en      = 1'b0;
    case (state)
      LOAD: begin
        if (xfer) begin
          wr_en      = 1'b1;
          count_next = word_count + CW'(1);
          if (ld.ld_last) begin
            state_next = HOLD;
          end else if (word_count == CW'(DEPTH - 1)) begin
            state_next = HOLD;
            err_next   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == HW'(RELEASE_CYCLES - 1)) state_next = RUN;
        else                                      hold_next  = hold_cnt + HW'(1);
      end
      RUN: begin
        if (reload) begin
          state_next = LOAD;
          count_next = '0;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // State, counters and registered outputs; reset is synchronous, active-low.
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= LOAD;
      word_count <= '0;
      hold_cnt   <= '0;
      err_trunc  <= 1'b0;
      ready_q    <= 1'b0;
      cpu_reset  <= 1'b0;
      load_done  <= 1'b0;
      fetch_ok   <= 1'b0;
    end else begin
      state      <= state_next;
      word_count <= count_next;
      hold_cnt   <= hold_next;
      err_trunc  <= err_next;
      ready_q    <= (state_next == LOAD) && (count_next < CW'(DEPTH));
      cpu_reset  <= (state_next == RUN);
      load_done  <= (state_next == RUN);
      fetch_ok   <= fetch_hit;
    end
  end

  // Writes are suppressed while reset is asserted so a reset never stores a word.
  dlx_imem_array #(.DEPTH(DEPTH)) u_array (
    .clock (clock),
    .we    (wr_en && reset),
    .waddr (word_count[AW-1:0]),
    .wdata (ld.ld_data),
    .raddr (idx),
    .rdata (rdata)
  );

  // The registered qualifier selects stored data or NOP for this fetch.
  assign inst_out = fetch_ok ? rdata : NOP_WORD;

endmodule

// File: tb/tb_dlx_prog_loader.sv
// Directed self-checking bench for dlx_prog_loader.
module tb_dlx_prog_loader;
  import dlx_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic        reload;
  logic [31:0] pc;
  logic [31:0] inst_out;
  logic        cpu_reset;
  logic        load_done;
  logic [6:0]  word_count;
  logic        err_trunc;

  int checks   = 0;
  int failures = 0;

  dlx_prog_loader_if ld_if ();

  dlx_prog_loader #(.DEPTH(64), .NOP_WORD(NOP), .RELEASE_CYCLES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .ld         (ld_if),
    .reload     (reload),
    .pc         (pc),
    .inst_out   (inst_out),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .word_count (word_count),
    .err_trunc  (err_trunc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one word and wait (bounded) for it to be accepted.
  task automatic send_word(input logic [31:0] d, input logic last);
    int waited = 0;
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = d;
    ld_if.ld_last  = last;
    while (!ld_if.ld_ready && waited < 16) begin
      step();
      waited++;
    end
    checks++;
    if (ld_if.ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_word_ready: ld_ready=%0b, required 1 within 16 cycles", ld_if.ld_ready);
    end
    step();
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
  endtask

  task automatic fetch_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    step();
    checks++;
    if (inst_out !== exp) begin
      failures++;
      $display("FAIL %s: inst_out=%h required %h (pc=%0d)", name, inst_out, exp, addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; reload = 1'b0; pc = '0;
    ld_if.ld_valid = 1'b0; ld_if.ld_data = '0; ld_if.ld_last = 1'b0;
    repeat (3) step();
    checks++; if (ld_if.ld_ready !== 1'b0) begin failures++; $display("FAIL reset_ld_ready: got %0b required 0", ld_if.ld_ready); end
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL reset_cpu_reset: got %0b required 0", cpu_reset); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL reset_load_done: got %0b required 0", load_done); end
    checks++; if (word_count !== 7'd0) begin failures++; $display("FAIL reset_word_count: got %0d required 0", word_count); end
    checks++; if (err_trunc !== 1'b0) begin failures++; $display("FAIL reset_err_trunc: got %0b required 0", err_trunc); end
    checks++; if (inst_out !== NOP) begin failures++; $display("FAIL reset_inst_out: got %h required %h", inst_out, NOP); end
    reset = 1'b1;
    step();
    checks++; if (ld_if.ld_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %0b required 1", ld_if.ld_ready); end
  endtask

  task automatic test_nominal();
    send_word(32'h4022_000F, 1'b0);
    send_word(32'h4043_000F, 1'b0);
    send_word(32'h0000_0000, 1'b1);
    checks++; if (word_count !== 7'd3) begin failures++; $display("FAIL nominal_count: got %0d required 3", word_count); end
    checks++; if (ld_if.ld_ready !== 1'b0) begin failures++; $display("FAIL nominal_ready_hold: got %0b required 0", ld_if.ld_ready); end
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL nominal_cpu_reset_e0: got %0b required 0", cpu_reset); end
    step();
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL nominal_cpu_reset_e1: got %0b required 0", cpu_reset); end
    step();
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL nominal_cpu_reset_e2: got %0b required 1", cpu_reset); end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL nominal_load_done: got %0b required 1", load_done); end
    checks++; if (err_trunc !== 1'b0) begin failures++; $display("FAIL nominal_err_trunc: got %0b required 0", err_trunc); end
    fetch_check("nominal_fetch_pc4", 32'd4, 32'h4043_000F);
    fetch_check("nominal_fetch_pc0", 32'd0, 32'h4022_000F);
  endtask

  task automatic test_fetch_range();
    fetch_check("range_unloaded_pc12", 32'd12, NOP);
    fetch_check("range_pc256", 32'd256, NOP);
    fetch_check("range_pc260_alias", 32'd260, NOP);
    fetch_check("range_pc5_low_bits", 32'd5, 32'h4043_000F);
  endtask

  task automatic test_truncation();
    reload = 1'b1;
    step();
    reload = 1'b0;
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL trunc_reload_cpu_reset: got %0b required 0", cpu_reset); end
    checks++; if (word_count !== 7'd0) begin failures++; $display("FAIL trunc_reload_count: got %0d required 0", word_count); end
    for (int i = 0; i < 64; i++) send_word(32'h1000_0000 + 32'(i), 1'b0);
    checks++; if (ld_if.ld_ready !== 1'b0) begin failures++; $display("FAIL trunc_ready_fall: got %0b required 0", ld_if.ld_ready); end
    checks++; if (err_trunc !== 1'b1) begin failures++; $display("FAIL trunc_err: got %0b required 1", err_trunc); end
    checks++; if (word_count !== 7'd64) begin failures++; $display("FAIL trunc_count: got %0d required 64", word_count); end
    ld_if.ld_valid = 1'b1; ld_if.ld_data = 32'h0BAD_0BAD;
    step();
    step();
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL trunc_run: cpu_reset=%0b required 1", cpu_reset); end
    step();
    checks++; if (word_count !== 7'd64) begin failures++; $display("FAIL trunc_no_65th: word_count=%0d required 64", word_count); end
    ld_if.ld_valid = 1'b0;
    fetch_check("trunc_fetch_last", 32'd252, 32'h1000_003F);
    fetch_check("trunc_fetch_first", 32'd0, 32'h1000_0000);
    fetch_check("trunc_fetch_pc256", 32'd256, NOP);
  endtask

  task automatic test_reload();
    reload = 1'b1;
    ld_if.ld_valid = 1'b1; ld_if.ld_data = 32'hAAAA_AAAA; ld_if.ld_last = 1'b1;
    step();
    reload = 1'b0; ld_if.ld_valid = 1'b0; ld_if.ld_last = 1'b0;
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL reload_cpu_reset: got %0b required 0", cpu_reset); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL reload_load_done: got %0b required 0", load_done); end
    checks++; if (word_count !== 7'd0) begin failures++; $display("FAIL reload_count: got %0d required 0", word_count); end
    checks++; if (ld_if.ld_ready !== 1'b1) begin failures++; $display("FAIL reload_ready: got %0b required 1", ld_if.ld_ready); end
    send_word(32'h2000_0001, 1'b0);
    send_word(32'h2000_0002, 1'b1);
    checks++; if (word_count !== 7'd2) begin failures++; $display("FAIL reload_new_count: got %0d required 2", word_count); end
    step();
    step();
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL reload_run: cpu_reset=%0b required 1", cpu_reset); end
    checks++; if (err_trunc !== 1'b1) begin failures++; $display("FAIL reload_err_kept: got %0b required 1", err_trunc); end
    fetch_check("reload_fetch0", 32'd0, 32'h2000_0001);
    fetch_check("reload_fetch1", 32'd4, 32'h2000_0002);
    fetch_check("reload_fetch2_nop", 32'd8, NOP);
  endtask

  task automatic test_backpressure();
    logic [31:0] vals [5] = '{32'h3000_0001, 32'h0, 32'h3000_0002, 32'h0, 32'h3000_0003};
    logic [6:0]  cnts [5] = '{7'd1, 7'd1, 7'd2, 7'd2, 7'd3};
    reload = 1'b1;
    step();
    reload = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_if.ld_valid = (i % 2 == 0);
      ld_if.ld_data  = vals[i];
      ld_if.ld_last  = (i == 4);
      step();
      checks++; if (word_count !== cnts[i]) begin failures++; $display("FAIL bp_count_%0d: got %0d required %0d", i, word_count, cnts[i]); end
      checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL bp_cpu_reset_%0d: got %0b required 0", i, cpu_reset); end
    end
    ld_if.ld_valid = 1'b0; ld_if.ld_last = 1'b0;
    step();
    step();
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL bp_run: cpu_reset=%0b required 1", cpu_reset); end
    fetch_check("bp_fetch0", 32'd0, 32'h3000_0001);
    fetch_check("bp_fetch1", 32'd4, 32'h3000_0002);
    fetch_check("bp_fetch2", 32'd8, 32'h3000_0003);
    fetch_check("bp_fetch3_nop", 32'd12, NOP);
  endtask

  task automatic test_reset_mid();
    reload = 1'b1;
    step();
    reload = 1'b0;
    send_word(32'h5000_0001, 1'b1);
    reset = 1'b0;
    step();
    checks++; if (ld_if.ld_ready !== 1'b0) begin failures++; $display("FAIL hold_rst_ready: got %0b required 0", ld_if.ld_ready); end
    checks++; if (word_count !== 7'd0) begin failures++; $display("FAIL hold_rst_count: got %0d required 0", word_count); end
    checks++; if (err_trunc !== 1'b0) begin failures++; $display("FAIL hold_rst_err: got %0b required 0", err_trunc); end
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL hold_rst_cpu_reset: got %0b required 0", cpu_reset); end
    reset = 1'b1;
    repeat (3) step();
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL hold_rst_stays_load: cpu_reset=%0b required 0", cpu_reset); end
    fetch_check("hold_rst_fetch_nop", 32'd0, NOP);
    send_word(32'h4000_0001, 1'b1);
    step();
    step();
    fetch_check("rst_reload_fetch", 32'd0, 32'h4000_0001);
    reset = 1'b0;
    step();
    checks++; if (inst_out !== NOP) begin failures++; $display("FAIL run_rst_inst_out: got %h required %h", inst_out, NOP); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL run_rst_load_done: got %0b required 0", load_done); end
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL run_rst_cpu_reset: got %0b required 0", cpu_reset); end
    checks++; if (word_count !== 7'd0) begin failures++; $display("FAIL run_rst_count: got %0d required 0", word_count); end
    reset = 1'b1;
    step();
    fetch_check("run_rst_fetch_nop", 32'd0, NOP);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_fetch_range();
    test_truncation();
    test_reload();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
